vend_ctrl_param: RTL and testbench
==================================

Name: vend_ctrl_param

Overview:
- Parametrised coin-accumulating vending controller, the next generation of the team's fixed-price candy FSM.
- Accepts 2-bit coin codes on confirmed clock edges and accumulates credit against a parametrised price.
- Issues product / product+change / cancel outcomes, with computed change and refund values.
- Adds an inactivity timeout auto-cancel and a programmable output hold time.
- Sits between the coin-input front end and the dispenser/change-return actuators.

Parameters:
- PRICE, 30, product price in currency units.
- COIN1, 5, value of coin code 2'b01.
- COIN2, 10, value of coin code 2'b10.
- COIN3, 25, value of coin code 2'b11.
- ACC_W, 6, credit/change width. Must hold PRICE+max(COIN)-1; elaboration error otherwise.
- TIMEOUT, 16, idle cycles with nonzero credit before auto-cancel. 0 disables the timeout.
- HOLD, 2, cycles an outcome code is held on out (minimum 1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- confirm  in  1  qualifies in on this edge.
- in  in  2  00=cancel, 01/10/11=COIN1/COIN2/COIN3.
- out  out  2  00=none, 10=vend exact, 11=vend+change, 01=cancelled.
- credit  out  ACC_W  current accumulated credit.
- change  out  ACC_W  change or refund amount; valid while out != 00, else 0.
- busy  out  1  high in outcome states; confirm is ignored while high.

Behaviour:
- Reset, applied synchronously on any edge with rst=1 and overriding everything:
  - state=IDLE, out=00, credit=0, change=0, busy=0, timer=0.
  - Reset mid-outcome abandons the outcome with no refund.
- States: IDLE, ACCUM, VEND, VEND_CHG, CANCEL. All outputs are registered, so a confirmed coin is visible on credit one cycle later.
- IDLE or ACCUM, confirm=1, in=coin:
  - sum = credit+coinval.
  - sum < PRICE: credit<=sum, go to ACCUM, timer<=0.
  - sum == PRICE: go to VEND, out<=10, change<=0.
  - sum > PRICE: go to VEND_CHG, out<=11, change<=sum-PRICE.
  - In both vend cases credit<=0.
- IDLE or ACCUM, confirm=1, in=00: go to CANCEL, out<=01, change<=credit (may be 0), credit<=0.
- ACCUM, confirm=0:
  - timer increments.
  - When timer reaches TIMEOUT-1 (TIMEOUT>0), behave exactly as a cancel on the next edge.
  - A confirmed coin or cancel on the same edge as expiry takes priority over the timeout.
- IDLE, confirm=0: hold, timer=0.
- VEND, VEND_CHG, CANCEL:
  - busy=1; out and change are held for HOLD cycles; confirm and in are ignored.
  - Then out<=00, change<=0, state IDLE.
  - The first coin accepted after an outcome is the one on the edge after busy drops.
- Arithmetic: unsigned ACC_W-bit. sum is computed at ACC_W+1 bits internally; the parameter check guarantees no overflow.
- in is sampled only when confirm=1. No metastability handling: both are synchronous inputs.
- A single timer counter is shared by the timeout count (ACCUM) and the hold count (outcome states). It is cleared on every state change.

Decomposition:
- Package vend_pkg holds:
  - state enum.
  - coin code constants (CODE_CANCEL, CODE_C1..C3).
  - out code constants (OUT_NONE, OUT_VEND, OUT_VEND_CHG, OUT_CANCEL).
  - a function mapping code to coin value from the parameters.
- One sub-module, vend_timer: a loadable/clearable up-counter with a terminal-count flag, width derived from max(TIMEOUT,HOLD). Everything else stays in vend_ctrl_param.

Test Plan:
- Defaults, confirm=1 with 01,10,10,10 on consecutive edges:
  - credit goes 5,15,25.
  - Fourth coin gives out=11, change=5 for 2 cycles, busy=1.
  - Then out=00, credit=0.
- 11 then 01: credit=25, then out=10, change=0 held 2 cycles, then IDLE.
- 10,10, then in=00 with confirm: out=01, change=20 for 2 cycles, credit=0.
- 10, then confirm=0 for 16 cycles: auto-cancel, out=01, change=10.
  - Repeat with a coin on the expiry edge: no cancel, credit=15.
- rst=1 asserted during VEND_CHG hold: next edge gives out=00, change=0, credit=0, busy=0.
  - Coins driven while busy=1 do not change credit.
- Overrides PRICE=45, COIN3=50, ACC_W=7: 11 from IDLE gives out=11, change=5.
  - Also check that ACC_W=5 with the defaults fails elaboration.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the parametrised vending controller.
//   state_e      : controller state encoding
//   CODE_*       : coin input codes on `in`
//   OUT_*        : outcome codes on `out`
//   coin_value() : coin code to currency value, given the configured coin values
//   max3()       : largest of three values, used for width and range checks
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_VEND,
    ST_VEND_CHG,
    ST_CANCEL
  } state_e;

  localparam logic [1:0] CODE_CANCEL = 2'b00;
  localparam logic [1:0] CODE_C1     = 2'b01;
  localparam logic [1:0] CODE_C2     = 2'b10;
  localparam logic [1:0] CODE_C3     = 2'b11;

  localparam logic [1:0] OUT_NONE     = 2'b00;
  localparam logic [1:0] OUT_VEND     = 2'b10;
  localparam logic [1:0] OUT_VEND_CHG = 2'b11;
  localparam logic [1:0] OUT_CANCEL   = 2'b01;

  // Map a coin code to its value; the cancel code is worth nothing.
  function automatic int unsigned coin_value(input logic [1:0] code,
                                             input int unsigned c1,
                                             input int unsigned c2,
                                             input int unsigned c3);
    int unsigned v;
    case (code)
      CODE_C1: v = c1;
      CODE_C2: v = c2;
      CODE_C3: v = c3;
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Clearable/loadable up-counter with a terminal-count flag.
//   clk, rst   : clock, synchronous active-high reset
//   clr_i      : clear to zero (highest priority)
//   ld_i       : load ld_val_i
//   ld_val_i   : load value
//   inc_i      : increment by one
//   tc_val_i   : terminal count compare value
//   count_o    : current count (registered)
//   tc_c_o     : count_o == tc_val_i (combinational from the register)
module vend_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         inc_i,
  input  logic [W-1:0] tc_val_i,
  output logic [W-1:0] count_o,
  output logic         tc_c_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear beats load beats increment.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (ld_i) begin
      count_d = ld_val_i;
    end else if (inc_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_c_o  = (count_q == tc_val_i);

endmodule

// File: rtl/vend_ctrl_param.sv
// Parametrised coin-accumulating vending controller.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   confirm : qualifies `in` on this edge
//   in      : 00 cancel, 01/10/11 coin 1/2/3
//   out     : 00 none, 10 vend exact, 11 vend + change, 01 cancelled
//   credit  : accumulated credit
//   change  : change or refund, nonzero only while out != 00
//   busy    : high in outcome states; confirm ignored meanwhile
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int unsigned PRICE   = 30,
  parameter int unsigned COIN1   = 5,
  parameter int unsigned COIN2   = 10,
  parameter int unsigned COIN3   = 25,
  parameter int unsigned ACC_W   = 6,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned HOLD    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             confirm,
  input  logic [1:0]       in,
  output logic [1:0]       out,
  output logic [ACC_W-1:0] credit,
  output logic [ACC_W-1:0] change,
  output logic             busy
);

  localparam int unsigned COIN_MAX = max3(COIN1, COIN2, COIN3);
  localparam int unsigned SW       = ACC_W + 1;
  localparam int unsigned TMAX     = (TIMEOUT > HOLD) ? TIMEOUT : HOLD;
  localparam int unsigned TW       = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [SW-1:0] PRICE_W = SW'(PRICE);
  localparam logic [TW-1:0] TO_TC   = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [TW-1:0] HOLD_TC = TW'(HOLD - 1);
  localparam bit            TO_EN   = (TIMEOUT > 0);

  // Highest reachable sum is (PRICE-1) + largest coin; it must fit in credit.
  if ((PRICE + COIN_MAX - 1) >= (64'd1 << ACC_W)) begin : g_bad_acc_w
    $error("vend_ctrl_param: ACC_W too small for PRICE + max coin - 1");
  end
  if (HOLD < 1) begin : g_bad_hold
    $error("vend_ctrl_param: HOLD must be at least 1");
  end

  state_e           state_q, state_d;
  logic [1:0]       out_q, out_d;
  logic [ACC_W-1:0] credit_q, credit_d;
  logic [ACC_W-1:0] change_q, change_d;
  logic             busy_q, busy_d;

  logic [SW-1:0]    coin_c;
  logic [SW-1:0]    sum_c;
  logic             tmr_clr_c;
  logic             tmr_inc_c;
  logic             tmr_tc_c;
  logic [TW-1:0]    tmr_tc_val_c;
  logic [TW-1:0]    tmr_count;

  // One counter serves both the idle timeout and the outcome hold.
  assign tmr_tc_val_c = (state_q == ST_ACCUM) ? TO_TC : HOLD_TC;

  vend_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmr_clr_c),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .inc_i    (tmr_inc_c),
    .tc_val_i (tmr_tc_val_c),
    .count_o  (tmr_count),
    .tc_c_o   (tmr_tc_c)
  );

  assign coin_c = SW'(coin_value(in, COIN1, COIN2, COIN3));
  assign sum_c  = {1'b0, credit_q} + coin_c;

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    credit_d  = credit_q;
    change_d  = change_q;
    busy_d    = busy_q;
    tmr_clr_c = 1'b0;
    tmr_inc_c = 1'b0;

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (confirm && (in == CODE_CANCEL)) begin
          state_d   = ST_CANCEL;
          out_d     = OUT_CANCEL;
          change_d  = credit_q;
          credit_d  = '0;
          busy_d    = 1'b1;
          tmr_clr_c = 1'b1;
        end else if (confirm) begin
          tmr_clr_c = 1'b1;
          if (sum_c < PRICE_W) begin
            state_d  = ST_ACCUM;
            credit_d = sum_c[ACC_W-1:0];
          end else if (sum_c == PRICE_W) begin
            state_d  = ST_VEND;
            out_d    = OUT_VEND;
            change_d = '0;
            credit_d = '0;
            busy_d   = 1'b1;
          end else begin
            state_d  = ST_VEND_CHG;
            out_d    = OUT_VEND_CHG;
            change_d = ACC_W'(sum_c - PRICE_W);
            credit_d = '0;
            busy_d   = 1'b1;
          end
        end else if (state_q == ST_ACCUM) begin
          // Idle with credit: expire into a cancel, otherwise keep counting.
          if (TO_EN && tmr_tc_c) begin
            state_d   = ST_CANCEL;
            out_d     = OUT_CANCEL;
            change_d  = credit_q;
            credit_d  = '0;
            busy_d    = 1'b1;
            tmr_clr_c = 1'b1;
          end else begin
            tmr_inc_c = 1'b1;
          end
        end else begin
          tmr_clr_c = 1'b1;
        end
      end

      ST_VEND, ST_VEND_CHG, ST_CANCEL: begin
        if (tmr_tc_c) begin
          state_d   = ST_IDLE;
          out_d     = OUT_NONE;
          change_d  = '0;
          busy_d    = 1'b0;
          tmr_clr_c = 1'b1;
        end else begin
          tmr_inc_c = 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        out_d     = OUT_NONE;
        credit_d  = '0;
        change_d  = '0;
        busy_d    = 1'b0;
        tmr_clr_c = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      out_q    <= OUT_NONE;
      credit_q <= '0;
      change_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      credit_q <= credit_d;
      change_q <= change_d;
      busy_q   <= busy_d;
    end
  end

  assign out    = out_q;
  assign credit = credit_q;
  assign change = change_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Scoreboard bench: each driven edge pushes the hand-derived outputs expected
// after that edge; a monitor pops and compares them just after the edge.
//   dut_a : default parameters
//   dut_b : PRICE=45, COIN3=50, ACC_W=7
module tb_vend_ctrl_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       conf_a = 1'b0, conf_b = 1'b0;
  logic [1:0] in_a = 2'b00, in_b = 2'b00;
  logic [1:0] out_a, out_b;
  logic [5:0] credit_a, change_a;
  logic [6:0] credit_b, change_b;
  logic       busy_a, busy_b;

  typedef struct {
    int         idx;
    bit         sel;
    logic [1:0] out;
    int         credit;
    int         change;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_step = 0;

  always #5 clk = ~clk;

  vend_ctrl_param dut_a (
    .clk     (clk),
    .rst     (rst),
    .confirm (conf_a),
    .in      (in_a),
    .out     (out_a),
    .credit  (credit_a),
    .change  (change_a),
    .busy    (busy_a)
  );

  vend_ctrl_param #(
    .PRICE (45),
    .COIN3 (50),
    .ACC_W (7)
  ) dut_b (
    .clk     (clk),
    .rst     (rst),
    .confirm (conf_b),
    .in      (in_b),
    .out     (out_b),
    .credit  (credit_b),
    .change  (change_b),
    .busy    (busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive one edge's inputs on the falling edge and queue the expected result.
  task automatic step(input bit s, input logic r, input logic c, input logic [1:0] code,
                      input logic [1:0] eo, input int ecr, input int ech, input logic eb);
    exp_t e;
    @(negedge clk);
    rst = r;
    if (!s) begin
      conf_a = c; in_a = code; conf_b = 1'b0; in_b = 2'b00;
    end else begin
      conf_b = c; in_b = code; conf_a = 1'b0; in_a = 2'b00;
    end
    e.idx = n_step; e.sel = s; e.out = eo; e.credit = ecr; e.change = ech; e.busy = eb;
    exp_q.push_back(e);
    n_step++;
  endtask

  // Monitor: compare just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!e.sel) begin
          chk($sformatf("a%0d.out", e.idx),    32'(out_a),    32'(e.out));
          chk($sformatf("a%0d.credit", e.idx), 32'(credit_a), 32'(e.credit));
          chk($sformatf("a%0d.change", e.idx), 32'(change_a), 32'(e.change));
          chk($sformatf("a%0d.busy", e.idx),   32'(busy_a),   32'(e.busy));
        end else begin
          chk($sformatf("b%0d.out", e.idx),    32'(out_b),    32'(e.out));
          chk($sformatf("b%0d.credit", e.idx), 32'(credit_b), 32'(e.credit));
          chk($sformatf("b%0d.change", e.idx), 32'(change_b), 32'(e.change));
          chk($sformatf("b%0d.busy", e.idx),   32'(busy_b),   32'(e.busy));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    step(0, 1, 0, 2'b00, 2'b00, 0, 0, 0);
    step(0, 1, 1, 2'b11, 2'b00, 0, 0, 0);
    step(1, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    // 5,10,10,10: vend with change 5, coins during hold ignored
    step(0, 0, 1, 2'b01, 2'b00, 5, 0, 0);
    step(0, 0, 1, 2'b10, 2'b00, 15, 0, 0);
    step(0, 0, 1, 2'b10, 2'b00, 25, 0, 0);
    step(0, 0, 1, 2'b10, 2'b11, 0, 5, 1);
    step(0, 0, 1, 2'b11, 2'b11, 0, 5, 1);
    step(0, 0, 1, 2'b11, 2'b00, 0, 0, 0);
    step(0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    // 25 then 5: exact vend, then first coin after busy drops is accepted
    step(0, 0, 1, 2'b11, 2'b00, 25, 0, 0);
    step(0, 0, 1, 2'b01, 2'b10, 0, 0, 1);
    step(0, 0, 0, 2'b00, 2'b10, 0, 0, 1);
    step(0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    step(0, 0, 1, 2'b01, 2'b00, 5, 0, 0);
    step(0, 0, 1, 2'b00, 2'b01, 0, 5, 1);
    step(0, 0, 0, 2'b00, 2'b01, 0, 5, 1);
    step(0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    // 10,10 then cancel: refund 20
    step(0, 0, 1, 2'b10, 2'b00, 10, 0, 0);
    step(0, 0, 1, 2'b10, 2'b00, 20, 0, 0);
    step(0, 0, 1, 2'b00, 2'b01, 0, 20, 1);
    step(0, 0, 0, 2'b00, 2'b01, 0, 20, 1);
    step(0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    // 10 then 16 idle edges: auto-cancel on the 16th
    step(0, 0, 1, 2'b10, 2'b00, 10, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 2'b00, 2'b00, 10, 0, 0);
    step(0, 0, 0, 2'b00, 2'b01, 0, 10, 1);
    step(0, 0, 0, 2'b00, 2'b01, 0, 10, 1);
    step(0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    // coin on the expiry edge wins over the timeout
    step(0, 0, 1, 2'b10, 2'b00, 10, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 2'b00, 2'b00, 10, 0, 0);
    step(0, 0, 1, 2'b01, 2'b00, 15, 0, 0);
    step(0, 0, 0, 2'b00, 2'b00, 15, 0, 0);
    step(0, 0, 1, 2'b00, 2'b01, 0, 15, 1);
    step(0, 0, 0, 2'b00, 2'b01, 0, 15, 1);
    step(0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    // reset during VEND_CHG hold abandons the outcome
    step(0, 0, 1, 2'b11, 2'b00, 25, 0, 0);
    step(0, 0, 1, 2'b10, 2'b11, 0, 5, 1);
    step(0, 1, 1, 2'b10, 2'b00, 0, 0, 0);
    step(0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    step(0, 0, 1, 2'b01, 2'b00, 5, 0, 0);

    // cancel from IDLE with zero credit
    step(0, 1, 0, 2'b00, 2'b00, 0, 0, 0);
    step(0, 0, 1, 2'b00, 2'b01, 0, 0, 1);
    step(0, 0, 0, 2'b00, 2'b01, 0, 0, 1);
    step(0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    // overridden pricing: 50 from IDLE gives change 5
    step(1, 0, 1, 2'b11, 2'b11, 0, 5, 1);
    step(1, 0, 0, 2'b00, 2'b11, 0, 5, 1);
    step(1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    // 5 then 50: change 10
    step(1, 0, 1, 2'b01, 2'b00, 5, 0, 0);
    step(1, 0, 1, 2'b11, 2'b11, 0, 10, 1);
    step(1, 0, 0, 2'b00, 2'b11, 0, 10, 1);
    step(1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    // 10,10,10,10,5: exact 45
    step(1, 0, 1, 2'b10, 2'b00, 10, 0, 0);
    step(1, 0, 1, 2'b10, 2'b00, 20, 0, 0);
    step(1, 0, 1, 2'b10, 2'b00, 30, 0, 0);
    step(1, 0, 1, 2'b10, 2'b00, 40, 0, 0);
    step(1, 0, 1, 2'b01, 2'b10, 0, 0, 1);
    step(1, 0, 0, 2'b00, 2'b10, 0, 0, 1);
    step(1, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    @(negedge clk);
    conf_a = 1'b0; conf_b = 1'b0;
    @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
